// File: rtl/skid_buffer.sv
// Two-entry skid buffer: registered valid/ready pipeline stage.
// in_ready depends only on state flops and rst, never on out_ready.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;
  logic             ld_main_in;
  logic             ld_main_skid;
  logic             ld_skid;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_data = main_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          ld_main_in = 1'b1;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        unique case (1'b1)
          (in_fire && out_fire): begin
            ld_main_in = 1'b1;
          end
          (in_fire && !out_fire): begin
            ld_skid   = 1'b1;
            state_nxt = FULL;
          end
          (!in_fire && out_fire): begin
            state_nxt = EMPTY;
          end
          default: ;
        endcase
      end
      FULL: begin
        if (out_fire) begin
          ld_main_skid = 1'b1;
          state_nxt    = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Main only moves on an accepted input or a skid promotion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in) begin
        main_q <= in_data;
      end else if (ld_main_skid) begin
        main_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= in_data;
      end
    end
  end

  always_comb begin
    out_valid = 1'b0;
    in_ready  = !rst;
    level     = 2'd0;
    unique case (state)
      EMPTY: ;
      BUSY: begin
        out_valid = 1'b1;
        level     = 2'd1;
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        level     = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_skid_buffer.sv
// Bench for skid_buffer: directed vector table, corner sequences,
// and random traffic against a queue-based reference.
module tb_skid_buffer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] level;

  int checks = 0;
  int errors = 0;

  skid_buffer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a queue of held words, capacity two.
  logic [7:0] mq[$];
  bit         m_in;
  bit         m_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      m_in  = in_valid && (mq.size() < 2);
      m_out = out_ready && (mq.size() > 0);
      if (m_out) void'(mq.pop_front());
      if (m_in) mq.push_back(in_data);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d,
                      input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       r;
    logic       ov;
    logic [7:0] od;
    logic [1:0] lv;
    logic       ir;
  } vec_t;

  vec_t tbl[17];

  logic       pv;
  logic [7:0] pd;
  logic       pr;
  int         pin;
  int         pout;

  initial begin
    tbl[0]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 8'h5A, 2'd1, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[2]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b1};
    tbl[3]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b0};
    tbl[4]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 8'hA1, 2'd2, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 2'd1, 1'b1};
    tbl[6]  = '{1'b1, 8'hA3, 1'b1, 1'b1, 8'hA3, 2'd1, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[8]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h33, 2'd1, 1'b1};
    tbl[9]  = '{1'b1, 8'h44, 1'b1, 1'b1, 8'h44, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[11] = '{1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[12] = '{1'b0, 8'h77, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};
    tbl[13] = '{1'b1, 8'hB1, 1'b0, 1'b1, 8'hB1, 2'd1, 1'b1};
    tbl[14] = '{1'b1, 8'hB2, 1'b0, 1'b1, 8'hB1, 2'd2, 1'b0};
    tbl[15] = '{1'b1, 8'hB3, 1'b1, 1'b1, 8'hB2, 2'd1, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);

    foreach (tbl[i]) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].r);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid),
          32'(tbl[i].ov));
      if (tbl[i].ov)
        chk($sformatf("vec%0d_out_data", i), 32'(out_data),
            32'(tbl[i].od));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lv));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready),
          32'(tbl[i].ir));
    end

    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b1);
      chk("stream_out_valid", 32'(out_valid), 1);
      chk("stream_out_data", 32'(out_data), 32'(i));
      chk("stream_level", 32'(level), 1);
      chk("stream_in_ready", 32'(in_ready), 1);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("stream_drain_level", 32'(level), 0);

    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    chk("full_level", 32'(level), 2);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_out_data", 32'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'hD1, 1'b1);
    chk("post_rst_out_valid", 32'(out_valid), 1);
    chk("post_rst_out_data", 32'(out_data), 32'hD1);
    chk("post_rst_level", 32'(level), 1);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_empty", 32'(out_valid), 0);

    pv = 1'b0;
    pd = 8'h00;
    pr = 1'b0;
    for (int c = 0; c < 12000; c++) begin
      chk("rnd_out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("rnd_level", 32'(level), 32'(mq.size()));
      chk("rnd_in_ready", 32'(in_ready), 32'(mq.size() < 2));
      if (mq.size() != 0)
        chk("rnd_out_data", 32'(out_data), 32'(mq[0]));
      if (pv && !pr) begin
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_out_data", 32'(out_data), 32'(pd));
      end
      pv = out_valid;
      pd = out_data;
      unique case ((c / 500) % 4)
        0: begin pin = 90; pout = 30; end
        1: begin pin = 50; pout = 90; end
        2: begin pin = 20; pout = 50; end
        default: begin pin = 70; pout = 70; end
      endcase
      in_valid  = $urandom_range(0, 99) < pin;
      in_data   = 8'($urandom);
      out_ready = $urandom_range(0, 99) < pout;
      pr        = out_ready;
      @(posedge clk);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
